// File: rtl/keyb_pkg.sv
// Shared definitions for the ET-3400 keyboard emulator and the key press sequencer.
package keyb_pkg;

  localparam int KEY_W = 6;

  localparam logic [KEY_W-1:0] KEY_NONE = 6'd0;
  localparam logic [KEY_W-1:0] KEY_MIN  = 6'd1;
  localparam logic [KEY_W-1:0] KEY_MAX  = 6'd16;

  // Emulator key-code encoding: 0 means "no key", 1..16 select a physical key.
  localparam logic [KEY_W-1:0] KEY_CODE_0    = 6'd1;
  localparam logic [KEY_W-1:0] KEY_CODE_1    = 6'd2;
  localparam logic [KEY_W-1:0] KEY_CODE_2    = 6'd3;
  localparam logic [KEY_W-1:0] KEY_CODE_3    = 6'd4;
  localparam logic [KEY_W-1:0] KEY_CODE_4    = 6'd5;
  localparam logic [KEY_W-1:0] KEY_CODE_5    = 6'd6;
  localparam logic [KEY_W-1:0] KEY_CODE_6    = 6'd7;
  localparam logic [KEY_W-1:0] KEY_CODE_7    = 6'd8;
  localparam logic [KEY_W-1:0] KEY_CODE_8    = 6'd9;
  localparam logic [KEY_W-1:0] KEY_CODE_9    = 6'd10;
  localparam logic [KEY_W-1:0] KEY_CODE_A    = 6'd11;
  localparam logic [KEY_W-1:0] KEY_CODE_B    = 6'd12;
  localparam logic [KEY_W-1:0] KEY_CODE_C    = 6'd13;
  localparam logic [KEY_W-1:0] KEY_CODE_D    = 6'd14;
  localparam logic [KEY_W-1:0] KEY_CODE_STAR = 6'd15;
  localparam logic [KEY_W-1:0] KEY_CODE_HASH = 6'd16;

  // Sequencer phases: waiting for work, key held down, key released (gap).
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESS   = 2'd1,
    RELEASE = 2'd2
  } seq_state_e;

  // True when a code maps onto a real key of the emulator.
  function automatic logic key_is_valid(input logic [KEY_W-1:0] code);
    return (code >= KEY_MIN) && (code <= KEY_MAX);
  endfunction

endpackage

// File: rtl/key_fifo.sv
// Small synchronous FIFO buffering key codes between the host producer and the sequencer.
// Pointers wrap naturally (power-of-two depth); full/empty come from the occupancy count.
module key_fifo #(
  parameter int WIDTH = 6,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic [CW-1:0]    count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  // A flush wins over everything; otherwise pushes need room and pops need data.
  assign do_push = push_i & ~full_o & ~flush_i;
  assign do_pop  = pop_i & ~empty_o & ~flush_i;

  // Next pointers and occupancy; a simultaneous push and pop leaves the count unchanged.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents need no reset because the count guards every read.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/key_press_sequencer.sv
// Presses queued key codes on the ET-3400 keyboard emulator one at a time, holding each
// for HOLD_CYCLES and then releasing for GAP_CYCLES so the monitor's scan debounces it.
module key_press_sequencer
  import keyb_pkg::*;
#(
  parameter int HOLD_CYCLES = 50000,
  parameter int GAP_CYCLES  = 50000,
  parameter int FIFO_DEPTH  = 8,
  parameter int CNT_W       = 17
) (
  input  logic                         Clock,
  input  logic                         Reset_N,
  input  logic [KEY_W-1:0]             Key_Code_I,
  input  logic                         Key_Valid_I,
  output logic                         Key_Ready_O,
  input  logic                         Abort_I,
  output logic [KEY_W-1:0]             Keyb_Value_O,
  output logic                         Busy_O,
  output logic [$clog2(FIFO_DEPTH):0]  Pending_O,
  output logic                         Bad_Key_O
);

  seq_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic             bad_q, bad_d;

  logic             accept, code_ok, fifo_push, fifo_pop;
  logic             fifo_full, fifo_empty;
  logic [KEY_W-1:0] fifo_head;

  // A transfer happens whenever the producer offers a code, there is room and no abort.
  // Out-of-range codes are swallowed by the handshake but never reach the queue.
  assign accept    = Key_Valid_I & Key_Ready_O & ~Abort_I;
  assign code_ok   = key_is_valid(Key_Code_I);
  assign fifo_push = accept & code_ok;
  assign bad_d     = accept & ~code_ok;

  key_fifo #(
    .WIDTH (KEY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (Clock),
    .rst_ni  (Reset_N),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .flush_i (Abort_I),
    .data_i  (Key_Code_I),
    .data_o  (fifo_head),
    .count_o (Pending_O),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign Key_Ready_O  = ~fifo_full;
  assign Keyb_Value_O = key_q;
  assign Bad_Key_O    = bad_q;
  assign Busy_O       = (state_q != IDLE) | ~fifo_empty;

  // Press/release sequencing: an abort cuts a press short but still honours the full gap.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    key_d    = key_q;
    fifo_pop = 1'b0;
    case (state_q)
      IDLE: begin
        if (!Abort_I && !fifo_empty) begin
          fifo_pop = 1'b1;
          key_d    = fifo_head;
          cnt_d    = CNT_W'(HOLD_CYCLES - 1);
          state_d  = PRESS;
        end
      end
      PRESS: begin
        if (Abort_I || (cnt_q == '0)) begin
          key_d   = KEY_NONE;
          cnt_d   = CNT_W'(GAP_CYCLES - 1);
          state_d = RELEASE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RELEASE: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        key_d   = KEY_NONE;
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // State, counter and output registers; reset drops any held key at once.
  always_ff @(posedge Clock or negedge Reset_N) begin
    if (!Reset_N) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      key_q   <= KEY_NONE;
      bad_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      key_q   <= key_d;
      bad_q   <= bad_d;
    end
  end

endmodule

// File: tb/tb_key_press_sequencer.sv
// Self-checking bench for key_press_sequencer: directed scenarios followed by random traffic,
// compared against a keystroke-level reference model and a press-order scoreboard.
module tb_key_press_sequencer;

  localparam int HOLD  = 4;
  localparam int GAP   = 3;
  localparam int DEPTH = 4;
  localparam int CNTW  = 3;

  logic       Clock;
  logic       Reset_N;
  logic [5:0] Key_Code_I;
  logic       Key_Valid_I;
  logic       Key_Ready_O;
  logic       Abort_I;
  logic [5:0] Keyb_Value_O;
  logic       Busy_O;
  logic [2:0] Pending_O;
  logic       Bad_Key_O;

  int nVectors;
  int nMiscompares;
  int pressCount;

  // Reference model: codes waiting in the buffer, the key currently shown,
  // how many hold cycles it still has, and how many gap cycles remain after release.
  int mq[$];
  int expQ[$];
  int mKey;
  int holdLeft;
  int relLeft;
  int mBad;

  key_press_sequencer #(
    .HOLD_CYCLES (HOLD),
    .GAP_CYCLES  (GAP),
    .FIFO_DEPTH  (DEPTH),
    .CNT_W       (CNTW)
  ) dut (
    .Clock        (Clock),
    .Reset_N      (Reset_N),
    .Key_Code_I   (Key_Code_I),
    .Key_Valid_I  (Key_Valid_I),
    .Key_Ready_O  (Key_Ready_O),
    .Abort_I      (Abort_I),
    .Keyb_Value_O (Keyb_Value_O),
    .Busy_O       (Busy_O),
    .Pending_O    (Pending_O),
    .Bad_Key_O    (Bad_Key_O)
  );

  // Free-running 10 ns clock.
  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    nVectors++;
    if (actual != expected) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic modelReset();
    mq.delete();
    expQ.delete();
    mKey     = 0;
    holdLeft = 0;
    relLeft  = 0;
    mBad     = 0;
  endtask

  function automatic int modelIdle();
    return (mKey == 0 && relLeft == 0) ? 1 : 0;
  endfunction

  // One clock of keystroke behaviour: a key stays down HOLD cycles (or until an abort),
  // then the line is quiet for GAP cycles plus one idle cycle before the next key is taken.
  task automatic modelStep();
    int accept;
    int goodCode;
    accept   = (Key_Valid_I && !Abort_I && (mq.size() < DEPTH)) ? 1 : 0;
    goodCode = (Key_Code_I >= 1 && Key_Code_I <= 16) ? 1 : 0;
    if (mKey != 0) begin
      if (Abort_I || holdLeft == 1) begin
        mKey    = 0;
        relLeft = GAP;
      end else begin
        holdLeft--;
      end
    end else if (relLeft > 0) begin
      relLeft--;
    end else if (!Abort_I && mq.size() > 0) begin
      mKey     = mq.pop_front();
      holdLeft = HOLD;
    end
    if (Abort_I) begin
      mq.delete();
      expQ.delete();
    end
    if (accept && goodCode) begin
      mq.push_back(int'(Key_Code_I));
      expQ.push_back(int'(Key_Code_I));
    end
    mBad = (accept && !goodCode) ? 1 : 0;
  endtask

  // Advance the model on every clock edge and follow the asynchronous reset.
  initial begin
    modelReset();
    forever begin
      @(posedge Clock or negedge Reset_N);
      if (!Reset_N) modelReset();
      else modelStep();
    end
  end

  // Monitor: on each falling edge compare every output with the model, and whenever a new
  // key appears pop the scoreboard to confirm keys come out in order, none lost or invented.
  initial begin
    int prevKey;
    int front;
    prevKey = 0;
    forever begin
      @(negedge Clock);
      checkOutput("keybValue", int'(Keyb_Value_O), mKey);
      checkOutput("pending", int'(Pending_O), mq.size());
      checkOutput("ready", int'(Key_Ready_O), (mq.size() < DEPTH) ? 1 : 0);
      checkOutput("busy", int'(Busy_O), (modelIdle() == 0 || mq.size() > 0) ? 1 : 0);
      checkOutput("badKey", int'(Bad_Key_O), mBad);
      if (Keyb_Value_O != 6'd0 && prevKey == 0) begin
        if (expQ.size() == 0) begin
          nVectors++;
          nMiscompares++;
          $display("[TB] FAIL pressUnexpected: got key %0d, expected no key (t=%0t)",
                   Keyb_Value_O, $time);
        end else begin
          front = expQ.pop_front();
          checkOutput("pressOrder", int'(Keyb_Value_O), front);
          pressCount++;
        end
      end
      prevKey = int'(Keyb_Value_O);
    end
  end

  // Offer one code and keep it offered until the handshake completes.
  task automatic applyStimulus(input int code);
    int done;
    done = 0;
    Key_Code_I  = 6'(code);
    Key_Valid_I = 1'b1;
    for (int i = 0; i < 200 && done == 0; i++) begin
      @(negedge Clock);
      done = (mq.size() < DEPTH && !Abort_I) ? 1 : 0;
      @(posedge Clock);
      #1;
    end
    Key_Valid_I = 1'b0;
    if (done == 0) begin
      nVectors++;
      nMiscompares++;
      $display("[TB] FAIL pushTimeout: code %0d never accepted, expected accept", code);
    end
  endtask

  // Hold abort for exactly one edge, optionally with a push offered that must be dropped.
  task automatic abortCycle(input int withPush, input int code);
    Key_Code_I  = 6'(code);
    Key_Valid_I = (withPush != 0);
    Abort_I     = 1'b1;
    @(posedge Clock);
    #1;
    Abort_I     = 1'b0;
    Key_Valid_I = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge Clock);
      #1;
    end
  endtask

  // Let all queued keys play out, then confirm every accepted key was pressed.
  task automatic waitDrain();
    int done;
    done = 0;
    for (int i = 0; i < 2000 && done == 0; i++) begin
      @(posedge Clock);
      #1;
      if (modelIdle() != 0 && mq.size() == 0) done = 1;
    end
    idleCycles(2);
    if (done == 0) begin
      nVectors++;
      nMiscompares++;
      $display("[TB] FAIL drainTimeout: sequencer still busy, expected idle");
    end
    checkOutput("drainScoreboard", expQ.size(), 0);
  endtask

  // Main sequence: reset, the directed scenarios, then randomized traffic.
  initial begin
    int r;
    int c;
    nVectors     = 0;
    nMiscompares = 0;
    pressCount   = 0;
    Reset_N      = 1'b1;
    Key_Code_I   = 6'd0;
    Key_Valid_I  = 1'b0;
    Abort_I      = 1'b0;
    #1 Reset_N = 1'b0;
    #1;
    checkOutput("rstKeyb", int'(Keyb_Value_O), 0);
    checkOutput("rstReady", int'(Key_Ready_O), 1);
    checkOutput("rstBusy", int'(Busy_O), 0);
    checkOutput("rstPending", int'(Pending_O), 0);
    checkOutput("rstBad", int'(Bad_Key_O), 0);
    repeat (2) @(negedge Clock);
    #2 Reset_N = 1'b1;
    @(posedge Clock);
    #1;

    $display("[TB] single key");
    applyStimulus(5);
    waitDrain();

    $display("[TB] back-to-back keys");
    applyStimulus(1);
    applyStimulus(2);
    applyStimulus(3);
    waitDrain();

    $display("[TB] fill the buffer");
    for (int k = 7; k <= 12; k++) applyStimulus(k);
    waitDrain();

    $display("[TB] invalid codes");
    applyStimulus(0);
    applyStimulus(17);
    idleCycles(3);
    checkOutput("badNoKey", int'(Keyb_Value_O), 0);
    waitDrain();

    $display("[TB] abort mid-press");
    applyStimulus(4);
    applyStimulus(6);
    applyStimulus(9);
    abortCycle(1, 11);
    checkOutput("abortKeyb", int'(Keyb_Value_O), 0);
    checkOutput("abortPending", int'(Pending_O), 0);
    waitDrain();

    $display("[TB] asynchronous reset mid-press");
    applyStimulus(13);
    idleCycles(2);
    checkOutput("preResetKeyb", int'(Keyb_Value_O), 13);
    #2 Reset_N = 1'b0;
    #1;
    checkOutput("asyncRstKeyb", int'(Keyb_Value_O), 0);
    checkOutput("asyncRstPending", int'(Pending_O), 0);
    checkOutput("asyncRstBusy", int'(Busy_O), 0);
    repeat (2) @(negedge Clock);
    #2 Reset_N = 1'b1;
    @(posedge Clock);
    #1;
    applyStimulus(16);
    waitDrain();

    $display("[TB] random traffic");
    for (int n = 0; n < 150; n++) begin
      r = int'($urandom_range(0, 99));
      if (r < 8) begin
        abortCycle(int'($urandom_range(0, 1)), int'($urandom_range(1, 16)));
      end else begin
        if (r < 18) begin
          c = int'($urandom_range(0, 63));
          if (c >= 1 && c <= 16) c = 0;
        end else begin
          c = int'($urandom_range(1, 16));
        end
        applyStimulus(c);
      end
      idleCycles(int'($urandom_range(0, 10)));
    end
    waitDrain();

    $display("[TB] %0d keys pressed in total", pressCount);
    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
